// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Boot-time program loader for the single-cycle RV32I core. It takes a byte
// stream over a valid/ready handshake and assembles little-endian 32-bit
// instruction words. Each word goes to the instruction-memory write port. The
// core is held in reset until the whole image has landed.
//
// Stream: N[7:0], N[15:8], then 4*N payload bytes (LSB of each word first),
// then one checksum byte when the checksum build option is enabled.
//
// Build option:
//   IMEM_LOADER_CHECKSUM_EN  - when defined, a trailing checksum byte is
//                              expected. It must equal the 8-bit sum of all
//                              payload bytes, otherwise the load ends in ERROR.
//
// Parameters:
//   ADDR_W      instruction-memory word-address width (capacity 2^ADDR_W words)
//
// Ports:
//   clk         core clock, all state updates on the rising edge
//   reset       synchronous, active-high reset
//   start       one-cycle pulse, begins a load from IDLE, DONE or ERROR
//   rx_data     incoming stream byte
//   rx_valid    rx_data is valid
//   rx_ready    loader accepts a byte this cycle
//   imem_we     instruction-memory write enable, one pulse per word
//   imem_addr   word address of the write
//   imem_wdata  instruction word being written
//   cpu_reset   reset to the core, high until a load completes
//   done        load completed successfully
//   error       load aborted (oversized header or bad checksum)
// -----------------------------------------------------------------------------
module imem_loader #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_reset,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR0  = 3'd1,
        HDR1  = 3'd2,
        DATA  = 3'd3,
        WRITE = 3'd4,
`ifdef IMEM_LOADER_CHECKSUM_EN
        CHECK = 3'd5,
`endif
        DONE  = 3'd6,
        ERROR = 3'd7
    } state_t;

    localparam int unsigned CAPACITY = 1 << ADDR_W;

    // State entered once the last payload word is written (or right after an
    // empty header).
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t S_LAST = CHECK;
`else
    localparam state_t S_LAST = DONE;
`endif

    // Output vector registered together with each state change:
    // {rx_ready, imem_we, cpu_reset, done, error}
    function automatic logic [4:0] state_outputs(input state_t s);
        logic rdy;
        rdy = (s == HDR0) || (s == HDR1) || (s == DATA);
`ifdef IMEM_LOADER_CHECKSUM_EN
        rdy = rdy || (s == CHECK);
`endif
        return {rdy, s == WRITE, s != DONE, s == DONE, s == ERROR};
    endfunction

    state_t          r_state;
    logic            r_rx_ready;
    logic            r_imem_we;
    logic            r_cpu_reset;
    logic            r_done;
    logic            r_error;
    // One bit wider than the address so a full-capacity count (N = 2^ADDR_W)
    // can be represented and compared.
    logic [ADDR_W:0] r_widx;
    logic [ADDR_W:0] r_n;
    logic [7:0]      r_n_lo;
    logic [1:0]      r_lane;
    logic [31:0]     r_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]      r_csum;
`endif

    logic            w_xfer;
    logic [15:0]     w_n_full;
    logic            w_n_too_big;
    logic [ADDR_W:0] w_widx_inc;

    assign w_xfer      = rx_valid & r_rx_ready;
    assign w_n_full    = {rx_data, r_n_lo};
    assign w_n_too_big = {16'd0, w_n_full} > CAPACITY;
    assign w_widx_inc  = r_widx + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            {r_rx_ready, r_imem_we, r_cpu_reset, r_done, r_error} <= state_outputs(IDLE);
            r_widx  <= '0;
            r_n     <= '0;
            r_n_lo  <= '0;
            r_lane  <= '0;
            r_word  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_csum  <= '0;
`endif
        end else begin
            case (r_state)
                IDLE, DONE, ERROR: begin
                    if (start) begin
                        r_state <= HDR0;
                        {r_rx_ready, r_imem_we, r_cpu_reset, r_done, r_error} <= state_outputs(HDR0);
                        r_widx  <= '0;
                        r_lane  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_csum  <= '0;
`endif
                    end
                end

                HDR0: begin
                    if (w_xfer) begin
                        r_n_lo  <= rx_data;
                        r_state <= HDR1;
                        {r_rx_ready, r_imem_we, r_cpu_reset, r_done, r_error} <= state_outputs(HDR1);
                    end
                end

                HDR1: begin
                    if (w_xfer) begin
                        // Truncation is exact whenever the count is in range.
                        r_n <= w_n_full[ADDR_W:0];
                        if (w_n_too_big) begin
                            r_state <= ERROR;
                            {r_rx_ready, r_imem_we, r_cpu_reset, r_done, r_error} <= state_outputs(ERROR);
                        end else if (w_n_full == 16'd0) begin
                            r_state <= S_LAST;
                            {r_rx_ready, r_imem_we, r_cpu_reset, r_done, r_error} <= state_outputs(S_LAST);
                        end else begin
                            r_state <= DATA;
                            {r_rx_ready, r_imem_we, r_cpu_reset, r_done, r_error} <= state_outputs(DATA);
                        end
                    end
                end

                DATA: begin
                    if (w_xfer) begin
                        r_word[{r_lane, 3'b000} +: 8] <= rx_data;
                        r_lane <= r_lane + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_csum <= r_csum + rx_data;
`endif
                        if (r_lane == 2'd3) begin
                            r_state <= WRITE;
                            {r_rx_ready, r_imem_we, r_cpu_reset, r_done, r_error} <= state_outputs(WRITE);
                        end
                    end
                end

                WRITE: begin
                    // imem_addr shows the pre-increment index during this cycle.
                    r_widx <= w_widx_inc;
                    if (w_widx_inc == r_n) begin
                        r_state <= S_LAST;
                        {r_rx_ready, r_imem_we, r_cpu_reset, r_done, r_error} <= state_outputs(S_LAST);
                    end else begin
                        r_state <= DATA;
                        {r_rx_ready, r_imem_we, r_cpu_reset, r_done, r_error} <= state_outputs(DATA);
                    end
                end

`ifdef IMEM_LOADER_CHECKSUM_EN
                CHECK: begin
                    if (w_xfer) begin
                        if (rx_data == r_csum) begin
                            r_state <= DONE;
                            {r_rx_ready, r_imem_we, r_cpu_reset, r_done, r_error} <= state_outputs(DONE);
                        end else begin
                            r_state <= ERROR;
                            {r_rx_ready, r_imem_we, r_cpu_reset, r_done, r_error} <= state_outputs(ERROR);
                        end
                    end
                end
`endif

                default: begin
                    r_state <= IDLE;
                    {r_rx_ready, r_imem_we, r_cpu_reset, r_done, r_error} <= state_outputs(IDLE);
                end
            endcase
        end
    end

    assign rx_ready   = r_rx_ready;
    assign imem_we    = r_imem_we;
    assign imem_addr  = r_widx[ADDR_W-1:0];
    assign imem_wdata = r_word;
    assign cpu_reset  = r_cpu_reset;
    assign done       = r_done;
    assign error      = r_error;

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//
// Self-checking bench for imem_loader. Streams are built from word lists.
// Writes seen on the memory port are logged and compared with the word list.
// The end-of-load status is compared with the result of the stream's rules
// (size limit, checksum). Honours IMEM_LOADER_CHECKSUM_EN like the design.
// -----------------------------------------------------------------------------
module tb_imem_loader;

    localparam int ADDR_W = 6;
    localparam int CAP    = 1 << ADDR_W;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    typedef logic [7:0]  bq_t[$];
    typedef logic [31:0] wq_t[$];
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_reset;
    logic              done;
    logic              error;

    int  n_cmp = 0;
    int  n_err = 0;
    wr_t wr_q[$];

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_reset  (cpu_reset),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    // Write log, sampled mid-cycle.
    always @(negedge clk) begin
        if (imem_we === 1'b1) wr_q.push_back({imem_addr, imem_wdata});
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_vals(input string nm);
        check({nm, ":rx_ready"},   32'(rx_ready),   32'd0);
        check({nm, ":imem_we"},    32'(imem_we),    32'd0);
        check({nm, ":imem_addr"},  32'(imem_addr),  32'd0);
        check({nm, ":imem_wdata"}, imem_wdata,      32'd0);
        check({nm, ":cpu_reset"},  32'(cpu_reset),  32'd1);
        check({nm, ":done"},       32'(done),       32'd0);
        check({nm, ":error"},      32'(error),      32'd0);
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    // mode 0: rx_valid held high, 1: toggles every cycle, 2: random gaps plus
    // random start pulses that the loader must ignore mid-stream.
    task automatic send(input string nm, input bq_t b, input int mode);
        int i   = 0;
        int cyc = 0;
        bit tog = 1'b1;
        while (i < b.size() && cyc < 4000) begin
            @(negedge clk);
            case (mode)
                0:       rx_valid = 1'b1;
                1:       begin rx_valid = tog; tog = ~tog; end
                default: rx_valid = ($urandom_range(0, 2) != 0);
            endcase
            start   = (mode == 2) && ($urandom_range(0, 7) == 0);
            rx_data = rx_valid ? b[i] : 8'($urandom);
            if (rx_valid && rx_ready) i++;
            cyc++;
        end
        @(negedge clk);
        rx_valid = 1'b0;
        start    = 1'b0;
        rx_data  = 8'h00;
        check({nm, ":bytes_accepted"}, 32'(i), 32'(b.size()));
    endtask

    // One complete load: builds the stream, runs it, and checks status, latency
    // and the logged writes against the word list.
    task automatic do_load(input string nm, input logic [15:0] n, input wq_t words,
                           input int mode, input bit bad);
        bq_t  b;
        bit   too_big;
        bit   fail_exp;
        int   lat;
        int   exp_cnt;
        logic [7:0] sum;
        too_big = (int'(n) > CAP);
        sum = 8'h00;
        b.push_back(n[7:0]);
        b.push_back(n[15:8]);
        foreach (words[k]) begin
            for (int j = 0; j < 4; j++) begin
                b.push_back(words[k][8*j +: 8]);
                sum = sum + words[k][8*j +: 8];
            end
        end
        if (CSUM && !too_big) b.push_back(bad ? sum + 8'd1 : sum);

        wr_q.delete();
        pulse_start();
        check({nm, ":hdr0_ready"}, 32'(rx_ready),  32'd1);
        check({nm, ":hdr0_cpurst"}, 32'(cpu_reset), 32'd1);
        check({nm, ":hdr0_done"},  32'(done),      32'd0);
        check({nm, ":hdr0_error"}, 32'(error),     32'd0);

        send(nm, b, mode);

        fail_exp = too_big || (bad && CSUM);
        lat = (fail_exp || CSUM || n == 16'd0) ? 0 : 1;
        if (lat == 1) begin
            check({nm, ":done_early"}, 32'(done),    32'd0);
            check({nm, ":last_we"},    32'(imem_we), 32'd1);
            @(negedge clk);
        end
        check({nm, ":done"},      32'(done),      32'(!fail_exp));
        check({nm, ":error"},     32'(error),     32'(fail_exp));
        check({nm, ":cpu_reset"}, 32'(cpu_reset), 32'(fail_exp));
        check({nm, ":rx_ready"},  32'(rx_ready),  32'd0);

        repeat (3) @(negedge clk);
        exp_cnt = too_big ? 0 : int'(n);
        check({nm, ":wr_count"}, 32'(wr_q.size()), 32'(exp_cnt));
        for (int k = 0; k < wr_q.size() && k < exp_cnt; k++) begin
            check($sformatf("%s:addr[%0d]", nm, k), 32'(wr_q[k].addr), 32'(k));
            check($sformatf("%s:data[%0d]", nm, k), wr_q[k].data, words[k]);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        wq_t plan;
        wq_t none;
        wq_t w;
        bq_t part;
        logic [15:0] n;

        reset    = 1'b1;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_vals("por");
        reset = 1'b0;

        plan.push_back(32'h00500093);
        plan.push_back(32'h00100113);

        do_load("plan_steady", 16'd2, plan, 0, 1'b0);
        do_load("plan_toggle", 16'd2, plan, 1, 1'b0);
        do_load("bad_csum",    16'd2, plan, 0, 1'b1);
        do_load("after_error", 16'd2, plan, 0, 1'b0);
        do_load("n_too_big",   16'h0041, none, 0, 1'b0);
        do_load("n_zero",      16'd0, none, 1, 1'b0);

        // Reset in the middle of a word: partial word dropped, nothing written.
        wr_q.delete();
        pulse_start();
        part.push_back(8'h02);
        part.push_back(8'h00);
        part.push_back(8'h93);
        part.push_back(8'h00);
        send("mid_rst", part, 0);
        reset = 1'b1;
        @(negedge clk);
        check_reset_vals("mid_rst");
        reset = 1'b0;
        check("mid_rst:wr_count", 32'(wr_q.size()), 32'd0);
        do_load("reload", 16'd2, plan, 0, 1'b0);

        // Reset and start in the same cycle from DONE: reset must win.
        @(negedge clk);
        start = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        start = 1'b0;
        reset = 1'b0;
        check_reset_vals("rst_vs_start");

        // Full capacity boundary.
        w.delete();
        for (int k = 0; k < CAP; k++) w.push_back($urandom);
        do_load("full_cap", 16'(CAP), w, 2, 1'b0);

        // Randomized loads.
        for (int it = 0; it < 10; it++) begin
            w.delete();
            if (it == 4) begin
                n = 16'($urandom_range(CAP + 1, 65535));
            end else begin
                n = 16'($urandom_range(0, 12));
                for (int k = 0; k < int'(n); k++) w.push_back($urandom);
            end
            do_load($sformatf("rnd%0d", it), n, w, int'($urandom_range(0, 2)),
                    CSUM && ($urandom_range(0, 3) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
